mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 88 ++++++++
 rtl/mc_decode.sv | 42 ++++
 rtl/mc_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle MIPS-subset controller:
//   - FSM state encoding (IF, ID, EXE, MEM, WB)
//   - opcode / funct constants of the supported instructions
//   - select encodings for RegDst, MemtoReg, ExtOp, ALUOp and NPCOp
//   - one-hot instruction-class bit positions plus small class helpers
// Optional feature macro used by mc_ctrl: MC_CTRL_MEM_WAIT_EN.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    // FSM states
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_e;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct codes for R-type (instr[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    // RegDst: write-address select
    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    // MemtoReg: write-data select
    localparam logic [1:0] WD_ALU   = 2'b00;
    localparam logic [1:0] WD_MEM   = 2'b01;
    localparam logic [1:0] WD_PC4   = 2'b10;

    // ExtOp: immediate extension
    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // ALUOp
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    // NPCOp: next-PC source
    localparam logic [1:0] NPC_PC4  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] NPC_RS   = 2'b11;

    // One-hot instruction-class bit positions
    localparam int CLS_ADDU  = 0;
    localparam int CLS_SUBU  = 1;
    localparam int CLS_ORI   = 2;
    localparam int CLS_LUI   = 3;
    localparam int CLS_LW    = 4;
    localparam int CLS_SW    = 5;
    localparam int CLS_BEQ   = 6;
    localparam int CLS_J     = 7;
    localparam int CLS_JAL   = 8;
    localparam int CLS_JR    = 9;
    localparam int CLS_ILL   = 10;
    localparam int CLS_W     = 11;

    typedef logic [CLS_W-1:0] cls_t;

    // Instructions that finish in ID (jumps and anything undecodable)
    function automatic logic cls_ends_in_id(input cls_t cls);
        return cls[CLS_J] | cls[CLS_JAL] | cls[CLS_JR] | cls[CLS_ILL];
    endfunction

    // Instructions whose EXE result goes straight to WB
    function automatic logic cls_alu_to_wb(input cls_t cls);
        return cls[CLS_ADDU] | cls[CLS_SUBU] | cls[CLS_ORI] | cls[CLS_LUI];
    endfunction

endpackage

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Purely combinational instruction classifier: maps op/funct to a one-hot
// instruction class. Exactly one bit of cls is set for every input; any
// opcode or R-type funct outside the supported subset yields CLS_ILL.
// Ports:
//   op    [5:0]      in   instr[31:26]
//   funct [5:0]      in   instr[5:0]
//   cls   [CLS_W-1:0] out one-hot instruction class
// -----------------------------------------------------------------------------
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output cls_t       cls
);

    // Classify the instruction from opcode, then funct for R-type
    always_comb begin
        cls = {CLS_W{1'b0}};
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls[CLS_ADDU] = 1'b1;
                    FN_SUBU: cls[CLS_SUBU] = 1'b1;
                    FN_JR:   cls[CLS_JR]   = 1'b1;
                    default: cls[CLS_ILL]  = 1'b1;
                endcase
            end
            OP_ORI:  cls[CLS_ORI] = 1'b1;
            OP_LUI:  cls[CLS_LUI] = 1'b1;
            OP_LW:   cls[CLS_LW]  = 1'b1;
            OP_SW:   cls[CLS_SW]  = 1'b1;
            OP_BEQ:  cls[CLS_BEQ] = 1'b1;
            OP_J:    cls[CLS_J]   = 1'b1;
            OP_JAL:  cls[CLS_JAL] = 1'b1;
            default: cls[CLS_ILL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl
// Multi-cycle controller for a MIPS subset (addu, subu, ori, lui, lw, sw,
// beq, j, jal, jr). Five-state FSM IF/ID/EXE/MEM/WB; outputs are decoded
// combinationally from the current state and the instruction class.
// Optional feature: define MC_CTRL_MEM_WAIT_EN to stall in MEM until
// mem_ready=1; otherwise mem_ready is ignored and MEM lasts one cycle.
// Ports:
//   clk, reset (sync, active-high)     in
//   op[5:0], funct[5:0], zero           in   instruction fields, ALU equal flag
//   mem_ready                           in   data-memory ready (wait build only)
//   PCWr, IRWr, RegWr, MemWr            out  write enables
//   RegDst, ALUSrc, MemtoReg, ExtOp,
//   ALUOp, NPCOp                        out  datapath selects
//   state[2:0]                          out  current FSM state (debug)
//   instr_done                          out  pulse in an instruction's last state
// -----------------------------------------------------------------------------
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [1:0] RegDst,
    output logic       ALUSrc,
    output logic [1:0] MemtoReg,
    output logic [1:0] ExtOp,
    output logic [1:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [2:0] state,
    output logic       instr_done
);

    state_e state_q;
    state_e state_d;
    cls_t   cls_s;
    logic   mem_go_s;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (cls_s)
    );

`ifdef MC_CTRL_MEM_WAIT_EN
    // MEM completes only once the data memory reports ready
    assign mem_go_s = mem_ready;
`else
    // MEM always completes in one cycle; mem_ready has no effect
    logic mem_ready_unused_s;
    assign mem_go_s           = 1'b1;
    assign mem_ready_unused_s = mem_ready;
`endif

    assign state = state_q;

    // State register with synchronous reset back to fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (cls_ends_in_id(cls_s)) begin
                    state_d = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (cls_s[CLS_LW] | cls_s[CLS_SW]) begin
                    state_d = S_MEM;
                end else if (cls_alu_to_wb(cls_s)) begin
                    state_d = S_WB;
                end else begin
                    // beq (and any unexpected class) finishes here
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                if (!mem_go_s) begin
                    state_d = S_MEM;
                end else if (cls_s[CLS_LW]) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    // Output decode: Moore per state, qualified by instruction class.
    // Everything is forced low while reset is held.
    always_comb begin
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        MemWr      = 1'b0;
        RegDst     = RD_RT;
        ALUSrc     = 1'b0;
        MemtoReg   = WD_ALU;
        ExtOp      = EXT_ZERO;
        ALUOp      = ALU_ADD;
        NPCOp      = NPC_PC4;
        instr_done = 1'b0;
        if (reset) begin
            PCWr = 1'b0;
        end else begin
            case (state_q)
                S_IF: begin
                    PCWr  = 1'b1;
                    IRWr  = 1'b1;
                    NPCOp = NPC_PC4;
                end
                S_ID: begin
                    if (cls_s[CLS_J]) begin
                        PCWr       = 1'b1;
                        NPCOp      = NPC_JMP;
                        instr_done = 1'b1;
                    end else if (cls_s[CLS_JR]) begin
                        PCWr       = 1'b1;
                        NPCOp      = NPC_RS;
                        instr_done = 1'b1;
                    end else if (cls_s[CLS_JAL]) begin
                        PCWr       = 1'b1;
                        NPCOp      = NPC_JMP;
                        RegWr      = 1'b1;
                        RegDst     = RD_RA;
                        MemtoReg   = WD_PC4;
                        instr_done = 1'b1;
                    end else if (cls_s[CLS_ILL]) begin
                        // Undecodable: retire silently without any write
                        instr_done = 1'b1;
                    end else begin
                        instr_done = 1'b0;
                    end
                end
                S_EXE: begin
                    if (cls_s[CLS_ADDU]) begin
                        ALUOp = ALU_ADD;
                    end else if (cls_s[CLS_SUBU]) begin
                        ALUOp = ALU_SUB;
                    end else if (cls_s[CLS_ORI]) begin
                        ALUSrc = 1'b1;
                        ExtOp  = EXT_ZERO;
                        ALUOp  = ALU_OR;
                    end else if (cls_s[CLS_LUI]) begin
                        ALUSrc = 1'b1;
                        ExtOp  = EXT_LUI;
                        ALUOp  = ALU_OR;
                    end else if (cls_s[CLS_LW] | cls_s[CLS_SW]) begin
                        ALUSrc = 1'b1;
                        ExtOp  = EXT_SIGN;
                        ALUOp  = ALU_ADD;
                    end else if (cls_s[CLS_BEQ]) begin
                        ALUOp      = ALU_SUB;
                        ExtOp      = EXT_SIGN;
                        PCWr       = zero;
                        NPCOp      = NPC_BR;
                        instr_done = 1'b1;
                    end else begin
                        ALUOp = ALU_ADD;
                    end
                end
                S_MEM: begin
                    if (cls_s[CLS_SW]) begin
                        // Store is held for the whole MEM stay; done on release
                        MemWr      = 1'b1;
                        instr_done = mem_go_s;
                    end else begin
                        MemWr = 1'b0;
                    end
                end
                S_WB: begin
                    instr_done = 1'b1;
                    if (cls_s[CLS_ADDU] | cls_s[CLS_SUBU]) begin
                        RegWr  = 1'b1;
                        RegDst = RD_RD;
                    end else if (cls_s[CLS_ORI] | cls_s[CLS_LUI]) begin
                        RegWr  = 1'b1;
                        RegDst = RD_RT;
                    end else if (cls_s[CLS_LW]) begin
                        RegWr    = 1'b1;
                        RegDst   = RD_RT;
                        MemtoReg = WD_MEM;
                    end else begin
                        RegWr = 1'b0;
                    end
                end
                default: begin
                    PCWr = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl
// Directed, self-checking bench for mc_ctrl. Walks each instruction through
// its states and compares state plus a packed control word against
// hand-computed values.
// Control word layout (16 bits, MSB first):
//   PCWr IRWr RegWr MemWr RegDst[2] ALUSrc MemtoReg[2] ExtOp[2] ALUOp[2]
//   NPCOp[2] instr_done
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       PCWr, IRWr, RegWr, MemWr, ALUSrc, instr_done;
    logic [1:0] RegDst, MemtoReg, ExtOp, ALUOp, NPCOp;
    logic [2:0] state;
    logic [15:0] obs_ctl;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EXE = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PCWr       (PCWr),
        .IRWr       (IRWr),
        .RegWr      (RegWr),
        .MemWr      (MemWr),
        .RegDst     (RegDst),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .ExtOp      (ExtOp),
        .ALUOp      (ALUOp),
        .NPCOp      (NPCOp),
        .state      (state),
        .instr_done (instr_done)
    );

    assign obs_ctl = {PCWr, IRWr, RegWr, MemWr, RegDst, ALUSrc, MemtoReg,
                      ExtOp, ALUOp, NPCOp, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build an expected control word from individual fields
    function automatic logic [15:0] cw(
        input logic pcwr, input logic irwr, input logic regwr, input logic memwr,
        input logic [1:0] regdst, input logic alusrc, input logic [1:0] memtoreg,
        input logic [1:0] extop, input logic [1:0] aluop, input logic [1:0] npcop,
        input logic done);
        return {pcwr, irwr, regwr, memwr, regdst, alusrc, memtoreg,
                extop, aluop, npcop, done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] es, input logic [15:0] ec);
        #1;
        checks++;
        assert (state === es) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
        end
        checks++;
        assert (obs_ctl === ec) else begin
            errors++;
            $error("FAIL %s ctl: observed %h expected %h", tag, obs_ctl, ec);
        end
    endtask

    logic [15:0] c_zero, c_if;

    initial begin
        c_zero = 16'h0000;
        c_if   = cw(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

        reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        chk("reset_hold", ST_IF, c_zero);
        reset = 1'b0;

        // addu: IF ID EXE WB, done on 4th cycle
        op = 6'b000000; funct = 6'b100001;
        chk("addu_if", ST_IF, c_if);
        tick(); chk("addu_id", ST_ID, c_zero);
        tick(); chk("addu_exe", ST_EXE, c_zero);
        tick(); chk("addu_wb", ST_WB, cw(1'b0,1'b0,1'b1,1'b0,2'b01,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1));
        tick(); chk("addu_next", ST_IF, c_if);

        // subu: EXE uses subtract
        funct = 6'b100011;
        tick(); chk("subu_id", ST_ID, c_zero);
        tick(); chk("subu_exe", ST_EXE, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0));
        tick(); chk("subu_wb", ST_WB, cw(1'b0,1'b0,1'b1,1'b0,2'b01,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1));
        tick(); chk("subu_next", ST_IF, c_if);

        // lw: 5 cycles
        op = 6'b100011; funct = 6'b000000;
        tick(); chk("lw_id", ST_ID, c_zero);
        tick(); chk("lw_exe", ST_EXE, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b01,2'b00,2'b00,1'b0));
        tick(); chk("lw_mem", ST_MEM, c_zero);
        tick(); chk("lw_wb", ST_WB, cw(1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b01,2'b00,2'b00,2'b00,1'b1));
        tick(); chk("lw_next", ST_IF, c_if);

        // sw
        op = 6'b101011;
        tick(); chk("sw_id", ST_ID, c_zero);
        tick(); chk("sw_exe", ST_EXE, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b01,2'b00,2'b00,1'b0));
        mem_ready = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
        // three not-ready cycles then ready: MEM held four cycles, one done
        tick(); chk("sw_wait1", ST_MEM, cw(1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0));
        tick(); chk("sw_wait2", ST_MEM, cw(1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0));
        tick(); chk("sw_wait3", ST_MEM, cw(1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0));
        tick();
        mem_ready = 1'b1;
        chk("sw_mem_rdy", ST_MEM, cw(1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1));
`else
        // mem_ready low must be ignored: single-cycle MEM
        tick(); chk("sw_mem", ST_MEM, cw(1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1));
`endif
        tick(); chk("sw_next", ST_IF, c_if);
        mem_ready = 1'b1;

        // ori
        op = 6'b001101;
        tick(); chk("ori_id", ST_ID, c_zero);
        tick(); chk("ori_exe", ST_EXE, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b00,2'b10,2'b00,1'b0));
        tick(); chk("ori_wb", ST_WB, cw(1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1));
        tick(); chk("ori_next", ST_IF, c_if);

        // lui
        op = 6'b001111;
        tick(); chk("lui_id", ST_ID, c_zero);
        tick(); chk("lui_exe", ST_EXE, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b10,2'b10,2'b00,1'b0));
        tick(); chk("lui_wb", ST_WB, cw(1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1));
        tick(); chk("lui_next", ST_IF, c_if);

        // beq taken
        op = 6'b000100; zero = 1'b1;
        tick(); chk("beq1_id", ST_ID, c_zero);
        tick(); chk("beq1_exe", ST_EXE, cw(1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b01,2'b01,2'b01,1'b1));
        tick(); chk("beq1_next", ST_IF, c_if);

        // beq not taken
        zero = 1'b0;
        tick(); chk("beq0_id", ST_ID, c_zero);
        tick(); chk("beq0_exe", ST_EXE, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b01,2'b01,2'b01,1'b1));
        tick(); chk("beq0_next", ST_IF, c_if);

        // j
        op = 6'b000010;
        tick(); chk("j_id", ST_ID, cw(1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,2'b10,1'b1));
        tick(); chk("j_next", ST_IF, c_if);

        // jr
        op = 6'b000000; funct = 6'b001000;
        tick(); chk("jr_id", ST_ID, cw(1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,2'b11,1'b1));
        tick(); chk("jr_next", ST_IF, c_if);

        // jal
        op = 6'b000011; funct = 6'b000000;
        tick(); chk("jal_id", ST_ID, cw(1'b1,1'b0,1'b1,1'b0,2'b10,1'b0,2'b10,2'b00,2'b00,2'b10,1'b1));
        tick(); chk("jal_next", ST_IF, c_if);

        // R-type with unknown funct: retire from ID, no writes
        op = 6'b000000; funct = 6'b000000;
        tick(); chk("badfn_id", ST_ID, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1));
        tick(); chk("badfn_next", ST_IF, c_if);

        // reset during MEM of lw aborts with no writes
        op = 6'b100011;
        tick(); chk("rlw_id", ST_ID, c_zero);
        tick(); chk("rlw_exe", ST_EXE, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b01,2'b00,2'b00,1'b0));
        tick(); chk("rlw_mem", ST_MEM, c_zero);
        reset = 1'b1;
        chk("rlw_rst_out", ST_MEM, c_zero);
        tick(); chk("rlw_rst_if", ST_IF, c_zero);
        reset = 1'b0;

        // illegal opcode: IF -> ID -> IF, done only
        op = 6'b111111;
        chk("ill_if", ST_IF, c_if);
        tick(); chk("ill_id", ST_ID, cw(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,2'b00,2'b00,1'b1));
        tick(); chk("ill_next", ST_IF, c_if);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
